de2_115_qsys_cpu_div_cell: RTL and testbench

//   Iterative radix-2 restoring integer divider for the Nios II CPU datapath.

---
 rtl/de2_115_qsys_cpu_div_pkg.sv | 9 +
 rtl/de2_115_qsys_cpu_div_cell_if.sv | 16 +
 rtl/de2_115_qsys_cpu_div_step.sv | 17 +
 rtl/de2_115_qsys_cpu_div_cell.sv | 74 +++++++
 tb/tb_de2_115_qsys_cpu_div_cell.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/de2_115_qsys_cpu_div_pkg.sv
// de2_115_qsys_cpu_div_pkg: shared FSM states, counter width and magnitude helper for the divider cell
package de2_115_qsys_cpu_div_pkg;
  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
  localparam int DIV_W = 32;
  localparam int CNT_W = $clog2(DIV_W) + 1;
  function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] value, input logic signed_flag);
    return (signed_flag && value[DIV_W-1]) ? -value : value;
  endfunction
endpackage

// File: rtl/de2_115_qsys_cpu_div_cell_if.sv
// de2_115_qsys_cpu_div_cell_if: CPU <-> divider start/busy/done bus (master = CPU, slave = divider)
interface de2_115_qsys_cpu_div_cell_if #(parameter int WIDTH = 32);
  logic             div_start;
  logic             div_signed;
  logic [WIDTH-1:0] div_src1;
  logic [WIDTH-1:0] div_src2;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quot;
  logic [WIDTH-1:0] div_rem;
  logic             div_by_zero;
  modport master(output div_start, div_signed, div_src1, div_src2,
                 input div_busy, div_done, div_quot, div_rem, div_by_zero);
  modport slave(input div_start, div_signed, div_src1, div_src2,
                output div_busy, div_done, div_quot, div_rem, div_by_zero);
endinterface

// File: rtl/de2_115_qsys_cpu_div_step.sv
// de2_115_qsys_cpu_div_step: one combinational restoring step on {rem,quot} against divisor
module de2_115_qsys_cpu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quot_next
);
  logic [WIDTH:0] sh;
  logic           ge;
  assign sh        = {rem, quot[WIDTH-1]};
  assign ge        = sh >= {1'b0, divisor};
  assign rem_next  = ge ? WIDTH'(sh - {1'b0, divisor}) : sh[WIDTH-1:0];
  assign quot_next = {quot[WIDTH-2:0], ge};
endmodule

// File: rtl/de2_115_qsys_cpu_div_cell.sv
// de2_115_qsys_cpu_div_cell: iterative radix-2 restoring DIV/DIVU/REM/REMU unit, one step per clock
// Ports: clk, reset (sync, active-high), bus (slave: start/signed/src1/src2 in; busy/done/quot/rem/by_zero out)
// Option: DIV_CELL_EARLY_OUT_EN skips iteration when |src1| < |src2| and divisor != 0
module de2_115_qsys_cpu_div_cell
  import de2_115_qsys_cpu_div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input logic clk,
  input logic reset,
  de2_115_qsys_cpu_div_cell_if.slave bus
);
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_r, quot_r, dvsr, src1_r, rem_n, quot_n, a1, a2;
  logic             neg_q, neg_r, zero_r, accept, early;
  assign a1     = abs_val(bus.div_src1, bus.div_signed);
  assign a2     = abs_val(bus.div_src2, bus.div_signed);
  assign accept = state == IDLE && bus.div_start;
`ifdef DIV_CELL_EARLY_OUT_EN
  assign early  = bus.div_src2 != '0 && a1 < a2;
`else
  assign early  = 1'b0;
`endif
  assign bus.div_busy = state != IDLE;
  de2_115_qsys_cpu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem(rem_r), .quot(quot_r), .divisor(dvsr), .rem_next(rem_n), .quot_next(quot_n)
  );
  always_comb begin
    state_n = accept ? (early ? FIX : ITER)
            : (state == ITER && cnt == CNT_W'(1)) ? FIX
            : state == FIX ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      rem_r           <= '0;
      quot_r          <= '0;
      dvsr            <= '0;
      src1_r          <= '0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      zero_r          <= 1'b0;
      bus.div_done    <= 1'b0;
      bus.div_quot    <= '0;
      bus.div_rem     <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      state        <= state_n;
      bus.div_done <= state == FIX;
      if (accept) begin
        cnt    <= CNT_W'(WIDTH);
        dvsr   <= a2;
        src1_r <= bus.div_src1;
        neg_q  <= bus.div_signed && (bus.div_src1[WIDTH-1] ^ bus.div_src2[WIDTH-1]);
        neg_r  <= bus.div_signed && bus.div_src1[WIDTH-1];
        zero_r <= bus.div_src2 == '0;
        rem_r  <= early ? a1 : '0;
        quot_r <= early ? '0 : a1;
      end
      if (state == ITER) begin
        cnt    <= cnt - CNT_W'(1);
        rem_r  <= rem_n;
        quot_r <= quot_n;
      end
      if (state == FIX) begin
        bus.div_quot    <= zero_r ? '1 : neg_q ? -quot_r : quot_r;
        bus.div_rem     <= zero_r ? src1_r : neg_r ? -rem_r : rem_r;
        bus.div_by_zero <= zero_r;
      end
    end
  end
endmodule

// File: tb/tb_de2_115_qsys_cpu_div_cell.sv
// tb_de2_115_qsys_cpu_div_cell: randomized and directed checks of the divider against an arithmetic model
module tb_de2_115_qsys_cpu_div_cell;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   pass = 0;
  int   total = 0;
  de2_115_qsys_cpu_div_cell_if #(.WIDTH(32)) bus();
  de2_115_qsys_cpu_div_cell #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic model(input logic [31:0] s1, input logic [31:0] s2, input logic sg,
                       output logic [31:0] q, output logic [31:0] r, output logic bz);
    longint a, b;
    a = sg ? longint'($signed(s1)) : longint'(s1);
    b = sg ? longint'($signed(s2)) : longint'(s2);
    bz = (s2 == 0);
    if (bz) begin
      q = 32'hFFFFFFFF;
      r = s1;
    end else if (sg && a == -64'sd2147483648 && b == -1) begin
      q = 32'h80000000;
      r = 32'h0;
    end else begin
      q = 32'(a / b);
      r = 32'(a % b);
    end
  endtask

  function automatic int exp_lat(logic [31:0] s1, logic [31:0] s2, logic sg);
`ifdef DIV_CELL_EARLY_OUT_EN
    longint m1, m2;
    m1 = (sg && s1[31]) ? -longint'($signed(s1)) : longint'(s1);
    m2 = (sg && s2[31]) ? -longint'($signed(s2)) : longint'(s2);
    if (s2 != 0 && m1 < m2) return 2;
`endif
    return 34;
  endfunction

  // Entered #1 after a rising edge; returns in the done cycle so a new start can follow immediately.
  task automatic run_div(input logic [31:0] s1, input logic [31:0] s2, input logic sg,
                         output int lat, output logic [31:0] q, output logic [31:0] r,
                         output logic bz, output logic busy_ok);
    bus.div_start = 1'b1;
    bus.div_src1 = s1;
    bus.div_src2 = s2;
    bus.div_signed = sg;
    busy_ok = 1'b1;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        bus.div_start = 1'b0;
        bus.div_src1 = $urandom;
        bus.div_src2 = $urandom;
        bus.div_signed = 1'($urandom);
      end
      if (bus.div_done) begin
        lat = k;
        if (bus.div_busy) busy_ok = 1'b0;
        break;
      end
      if (!bus.div_busy) busy_ok = 1'b0;
    end
    q = bus.div_quot;
    r = bus.div_rem;
    bz = bus.div_by_zero;
  endtask

  task automatic test_reset();
    total++;
    if ({bus.div_busy, bus.div_done, bus.div_quot, bus.div_rem, bus.div_by_zero} !== 67'h0)
      $display("FAIL reset_state: busy=%b done=%b quot=%h rem=%h bz=%b, required all zero",
               bus.div_busy, bus.div_done, bus.div_quot, bus.div_rem, bus.div_by_zero);
    else pass++;
  endtask

  task automatic test_directed();
    logic [64:0] tbl [10];
    logic [31:0] q, r, eq, er;
    logic bz, ebz, bok;
    int lat;
    tbl = '{{32'd100, 32'd7, 1'b0}, {32'hFFFFFFF9, 32'd2, 1'b1}, {32'd7, 32'hFFFFFFFE, 1'b1},
            {32'h1234, 32'd0, 1'b1}, {32'h1234, 32'd0, 1'b0}, {32'h80000000, 32'hFFFFFFFF, 1'b1},
            {32'd5, 32'd9, 1'b0}, {32'hFFFFFFFB, 32'd0, 1'b1}, {32'd0, 32'd5, 1'b0},
            {32'hFFFFFFFF, 32'd1, 1'b0}};
    foreach (tbl[i]) begin
      run_div(tbl[i][64:33], tbl[i][32:1], tbl[i][0], lat, q, r, bz, bok);
      model(tbl[i][64:33], tbl[i][32:1], tbl[i][0], eq, er, ebz);
      total++;
      if ({q, r, bz} !== {eq, er, ebz})
        $display("FAIL directed_result[%0d]: quot=%h rem=%h bz=%b, required quot=%h rem=%h bz=%b",
                 i, q, r, bz, eq, er, ebz);
      else pass++;
      total++;
      if (lat !== exp_lat(tbl[i][64:33], tbl[i][32:1], tbl[i][0]) || !bok)
        $display("FAIL directed_latency[%0d]: done at N+%0d busy_ok=%b, required N+%0d busy_ok=1",
                 i, lat, bok, exp_lat(tbl[i][64:33], tbl[i][32:1], tbl[i][0]));
      else pass++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s1, s2, q, r, eq, er;
    logic sg, bz, ebz, bok;
    int lat;
    for (int i = 0; i < 4; i++) begin
      s1 = $urandom;
      s2 = (i == 2) ? 32'd0 : 32'($urandom_range(1, 5000));
      sg = 1'(i);
      run_div(s1, s2, sg, lat, q, r, bz, bok);
      model(s1, s2, sg, eq, er, ebz);
      total++;
      if ({q, r, bz} !== {eq, er, ebz} || lat !== exp_lat(s1, s2, sg) || !bok)
        $display("FAIL back_to_back[%0d]: quot=%h rem=%h bz=%b lat=%0d, required quot=%h rem=%h bz=%b lat=%0d",
                 i, q, r, bz, lat, eq, er, ebz, exp_lat(s1, s2, sg));
      else pass++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    int lat = -1;
    bus.div_start = 1'b1;
    bus.div_src1 = 32'd1000;
    bus.div_src2 = 32'd10;
    bus.div_signed = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      bus.div_start = (k == 5);
      if (k == 5) begin
        bus.div_src1 = 32'd77;
        bus.div_src2 = 32'd3;
      end
      if (bus.div_done) begin
        dones++;
        if (lat < 0) lat = k;
      end
    end
    total++;
    if (dones !== 1 || lat !== 34)
      $display("FAIL ignore_start_done: dones=%0d first=N+%0d, required dones=1 at N+34", dones, lat);
    else pass++;
    total++;
    if ({bus.div_quot, bus.div_rem} !== {32'd100, 32'd0})
      $display("FAIL ignore_start_result: quot=%h rem=%h, required quot=00000064 rem=00000000",
               bus.div_quot, bus.div_rem);
    else pass++;
  endtask

  task automatic test_reset_abort();
    logic [31:0] q, r;
    logic bz, bok;
    int lat;
    int dones = 0;
    bus.div_start = 1'b1;
    bus.div_src1 = 32'd12345;
    bus.div_src2 = 32'd7;
    bus.div_signed = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #1;
      bus.div_start = 1'b0;
      reset = (k == 10);
    end
    total++;
    if ({bus.div_busy, bus.div_done, bus.div_quot, bus.div_rem, bus.div_by_zero} !== 67'h0)
      $display("FAIL reset_abort_state: busy=%b done=%b quot=%h rem=%h bz=%b, required all zero",
               bus.div_busy, bus.div_done, bus.div_quot, bus.div_rem, bus.div_by_zero);
    else pass++;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.div_done) dones++;
    end
    total++;
    if (dones !== 0) $display("FAIL reset_abort_no_done: dones=%0d, required 0", dones);
    else pass++;
    run_div(32'd9, 32'd3, 1'b0, lat, q, r, bz, bok);
    total++;
    if ({q, r, bz} !== {32'd3, 32'd0, 1'b0} || lat !== 34)
      $display("FAIL reset_abort_next: quot=%h rem=%h bz=%b lat=%0d, required quot=00000003 rem=00000000 bz=0 lat=34",
               q, r, bz, lat);
    else pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [31:0] s1, s2, q, r, eq, er;
    logic sg, bz, ebz, bok;
    int lat, sel;
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 7));
      s1 = (sel == 7) ? 32'h80000000 : $urandom;
      s2 = (sel == 0) ? 32'd0 : (sel < 3) ? 32'($urandom_range(1, 300)) : (sel == 7) ? 32'hFFFFFFFF : $urandom;
      sg = 1'($urandom);
      run_div(s1, s2, sg, lat, q, r, bz, bok);
      model(s1, s2, sg, eq, er, ebz);
      total++;
      if ({q, r, bz} !== {eq, er, ebz} || lat !== exp_lat(s1, s2, sg) || !bok)
        $display("FAIL random[%0d] %h/%h s=%b: quot=%h rem=%h bz=%b lat=%0d, required quot=%h rem=%h bz=%b lat=%0d",
                 i, s1, s2, sg, q, r, bz, lat, eq, er, ebz, exp_lat(s1, s2, sg));
      else pass++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.div_start = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_src1 = '0;
    bus.div_src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    test_directed();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
